program_counter_v2: RTL and testbench

//   Parametrised program counter that generates the instruction memory address for the sequencer.

---
 rtl/program_counter_v2.sv | 103 ++++++++++
 tb/tb_program_counter_v2.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/program_counter_v2.sv
// rtl/program_counter_v2.sv - sequencer program counter with paged increment, branch and call/return stack
// Optional macro PC_STACK_EN enables the return-address stack (call/ret); without it they are ignored.
module program_counter_v2 #(
    parameter int ADDR_W      = 8,
    parameter int LSB_W       = 4,
    parameter int JMP_W       = 6,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              update_msbs,
    input  logic              update_lsbs,
    input  logic              jump,
    input  logic [JMP_W-1:0]  jump_destination,
    input  logic              branch,
    input  logic [JMP_W-1:0]  branch_offset,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    localparam int MSB_W = ADDR_W - LSB_W;

    // Address chosen by the non-stack strobes; single-field increments wrap without carry.
    logic [ADDR_W-1:0] seq_addr;

    always_comb begin
        seq_addr = mem_addr;
        if (jump) begin
            seq_addr = ADDR_W'(jump_destination);
        end else if (branch) begin
            seq_addr = mem_addr + ADDR_W'($signed(branch_offset));
        end else if (update_lsbs && update_msbs) begin
            seq_addr = mem_addr + ADDR_W'(1);
        end else if (update_lsbs) begin
            seq_addr[LSB_W-1:0] = mem_addr[LSB_W-1:0] + LSB_W'(1);
        end else if (update_msbs) begin
            seq_addr[ADDR_W-1:LSB_W] = mem_addr[ADDR_W-1:LSB_W] + MSB_W'(1);
        end
    end

`ifdef PC_STACK_EN
    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [PTR_W-1:0]  sp;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              err_q;

    assign push_idx    = IDX_W'(sp);
    assign top_idx     = IDX_W'(sp - PTR_W'(1));
    assign stack_full  = (sp == PTR_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign stack_err   = err_q;

    // Storage is not cleared on reset; the pointer reset alone discards the contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
            sp       <= '0;
            err_q    <= 1'b0;
        end else if (ret) begin
            if (!stack_empty) begin
                mem_addr <= stack_mem[top_idx];
                sp       <= sp - PTR_W'(1);
            end else begin
                err_q <= 1'b1;
            end
        end else if (call) begin
            if (!stack_full) begin
                stack_mem[push_idx] <= mem_addr + ADDR_W'(1);
                sp                  <= sp + PTR_W'(1);
                mem_addr            <= ADDR_W'(jump_destination);
            end else begin
                err_q <= 1'b1;
            end
        end else begin
            mem_addr <= seq_addr;
        end
    end
`else
    logic unused_stack_strobes;
    assign unused_stack_strobes = call ^ ret;

    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_err   = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
        end else begin
            mem_addr <= seq_addr;
        end
    end
`endif

endmodule

// File: tb/tb_program_counter_v2.sv
// tb/tb_program_counter_v2.sv - scoreboard bench for program_counter_v2 against an arithmetic reference model
module tb_program_counter_v2;

    localparam int ADDR_W = 8;
    localparam int LSB_W  = 4;
    localparam int JMP_W  = 6;
    localparam int DEPTH  = 4;
    localparam int ASPAN  = 1 << ADDR_W;
    localparam int LSPAN  = 1 << LSB_W;
    localparam int MSPAN  = 1 << (ADDR_W - LSB_W);
    localparam int JSPAN  = 1 << JMP_W;
`ifdef PC_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              update_msbs = 1'b0;
    logic              update_lsbs = 1'b0;
    logic              jump = 1'b0;
    logic [JMP_W-1:0]  jump_destination = '0;
    logic              branch = 1'b0;
    logic [JMP_W-1:0]  branch_offset = '0;
    logic              call = 1'b0;
    logic              ret = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;

    program_counter_v2 #(
        .ADDR_W(ADDR_W), .LSB_W(LSB_W), .JMP_W(JMP_W), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .update_msbs(update_msbs), .update_lsbs(update_lsbs),
        .jump(jump), .jump_destination(jump_destination),
        .branch(branch), .branch_offset(branch_offset),
        .call(call), .ret(ret),
        .mem_addr(mem_addr), .stack_full(stack_full),
        .stack_empty(stack_empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              full;
        logic              empty;
        logic              err;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference state: address as an integer, stack as a queue of return addresses.
    int    m_addr = 0;
    int    m_stack[$];
    bit    m_err = 1'b0;

    // Monitor: the registered outputs settle after each edge; compare on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            resp_t e;
            e = exp_q.pop_front();
            checks++;
            if (mem_addr !== e.addr || stack_full !== e.full ||
                stack_empty !== e.empty || stack_err !== e.err) begin
                errors++;
                $display("FAIL scoreboard t=%0t actual addr=%02h full=%b empty=%b err=%b required addr=%02h full=%b empty=%b err=%b",
                         $time, mem_addr, stack_full, stack_empty, stack_err, e.addr, e.full, e.empty, e.err);
            end
        end
    end

    task automatic model_step(input bit r, um, ul, j, br, c, rt, input int jd, bo);
        int off;
        if (r) begin
            m_addr = 0;
            m_stack.delete();
            m_err = 1'b0;
        end else if (STK && rt) begin
            if (m_stack.size() > 0) m_addr = m_stack.pop_back();
            else m_err = 1'b1;
        end else if (STK && c) begin
            if (m_stack.size() < DEPTH) begin
                m_stack.push_back((m_addr + 1) % ASPAN);
                m_addr = jd;
            end else begin
                m_err = 1'b1;
            end
        end else if (j) begin
            m_addr = jd;
        end else if (br) begin
            off = (bo >= JSPAN / 2) ? bo - JSPAN : bo;
            m_addr = (m_addr + off + ASPAN) % ASPAN;
        end else if (ul && um) begin
            m_addr = (m_addr + 1) % ASPAN;
        end else if (ul) begin
            m_addr = (m_addr / LSPAN) * LSPAN + (m_addr % LSPAN + 1) % LSPAN;
        end else if (um) begin
            m_addr = ((m_addr / LSPAN + 1) % MSPAN) * LSPAN + m_addr % LSPAN;
        end
    endtask

    // Drive one cycle of strobes, advance the model at the edge and queue the expected response.
    task automatic apply(input bit r, um, ul, j, input int jd, input bit br, input int bo,
                         input bit c, rt);
        resp_t e;
        rst = r; update_msbs = um; update_lsbs = ul; jump = j; branch = br; call = c; ret = rt;
        jump_destination = JMP_W'(jd);
        branch_offset = JMP_W'(bo);
        @(posedge clk);
        model_step(r, um, ul, j, br, c, rt, jd, bo);
        e.addr  = ADDR_W'(m_addr);
        e.full  = (m_stack.size() == DEPTH);
        e.empty = (m_stack.size() == 0);
        e.err   = m_err;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic expect_addr(input string name, input logic [ADDR_W-1:0] req);
        checks++;
        if (mem_addr !== req) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", name, mem_addr, req);
        end
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        // Reset with every strobe high.
        apply(1, 1, 1, 1, 63, 1, 63, 1, 1);
        apply(1, 1, 1, 1, 63, 1, 63, 1, 1);
        expect_addr("reset_addr", 8'h00);

        // In-page increment wraps, then a combined increment carries into the page.
        repeat (15) apply(0, 0, 1, 0, 0, 0, 0, 0, 0);
        expect_addr("lsb_to_0f", 8'h0F);
        apply(0, 1, 1, 0, 0, 0, 0, 0, 0);
        expect_addr("carry_to_10", 8'h10);
        repeat (18) apply(0, 0, 1, 0, 0, 0, 0, 0, 0);
        expect_addr("lsb_wrap_12", 8'h12);
        repeat (16) apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_addr("msb_wrap_12", 8'h12);

        // Jumps and signed branches, including wrap below zero.
        apply(0, 0, 0, 1, 8'h0F, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 8'h0A, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 1, 8'h3F, 0, 0);
        expect_addr("branch_neg1", 8'h09);
        apply(0, 0, 0, 0, 0, 1, 8'h04, 0, 0);
        expect_addr("branch_pos4", 8'h0D);
        apply(0, 0, 0, 1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 1, 8'h3F, 0, 0);
        expect_addr("branch_wrap_ff", 8'hFF);
        apply(0, 0, 0, 0, 0, 1, 8'h20, 0, 0);
        expect_addr("branch_min", 8'hDF);

`ifdef PC_STACK_EN
        apply(0, 0, 0, 1, 8'h05, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 8'h20, 0, 0, 1, 0);
        expect_addr("call_target", 8'h20);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_addr("ret_addr", 8'h06);
        apply(0, 0, 0, 0, 8'h30, 0, 0, 1, 1);
        expect_addr("ret_wins_empty", 8'h06);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 0, 8 * i + 3, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 8'h11, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 8'h22, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
`else
        apply(0, 0, 0, 1, 8'h11, 0, 0, 1, 0);
        expect_addr("call_jump_acts", 8'h11);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_addr("ret_held", 8'h11);
        apply(0, 0, 0, 0, 8'h07, 1, 8'h02, 1, 1);
        expect_addr("ret_call_branch", 8'h13);
`endif

        // Randomised strobes, weighted so stack edges and rare resets are exercised.
        for (int i = 0; i < 400; i++) begin
            n = $urandom_range(0, 99);
            apply(n < 2, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, JSPAN - 1),
                  $urandom_range(0, 4) == 0, $urandom_range(0, JSPAN - 1),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
        end
        idle();

        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
